// File: rtl/wb_write_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue_if
// Description : Bundle of the write-queue handshake, register-file write port
//               and forwarding snoop signals.
//               master : datapath / register-file side (drives requests,
//                        read addresses and drain permission)
//               slave  : the write queue itself
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_queue_if #(
  parameter int bit_size = 32,
  parameter int PTR_W    = 2
);
  logic                enq_valid;
  logic                enq_ready;
  logic [4:0]          enq_addr;
  logic [bit_size-1:0] enq_data;
  logic                drain_en;
  logic                RegWrite;
  logic [4:0]          Write_addr;
  logic [bit_size-1:0] Write_data;
  logic [4:0]          Read_addr_1;
  logic [4:0]          Read_addr_2;
  logic                fwd_hit_1;
  logic [bit_size-1:0] fwd_data_1;
  logic                fwd_hit_2;
  logic [bit_size-1:0] fwd_data_2;
  logic [PTR_W:0]      count;
  logic                empty;

  modport master (
    output enq_valid, enq_addr, enq_data, drain_en, Read_addr_1, Read_addr_2,
    input  enq_ready, RegWrite, Write_addr, Write_data,
           fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, count, empty
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, drain_en, Read_addr_1, Read_addr_2,
    output enq_ready, RegWrite, Write_addr, Write_data,
           fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, count, empty
  );
endinterface
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue
// Description : Writeback FIFO in front of the 32-entry register file write
//               port. Buffers requests, drains one per cycle through a
//               registered output stage (RegWrite/Write_addr/Write_data) and
//               forwards pending data to the two snooped read addresses.
// Ports       : clk, rst (async, active-high)
//               bus (wb_write_queue_if.slave): enq_* request handshake,
//               drain_en, register-file write port, Read_addr_*/fwd_* snoop,
//               count, empty.
// Options     : WBQ_COALESCE_EN - a request to the same address as the
//               youngest queued entry overwrites that entry's data.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_queue #(
  parameter int bit_size = 32,
  parameter int DEPTH    = 4,
  parameter int PTR_W    = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  wb_write_queue_if.slave    bus
);

  localparam logic [PTR_W:0]   c_full     = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   c_cnt_one  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] c_ptr_one  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [4:0]          mem_addr_q [DEPTH];
  logic [bit_size-1:0] mem_data_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                regwrite_q;
  logic [4:0]          waddr_q;
  logic [bit_size-1:0] wdata_q;

  logic                w_enq_ready;
  logic                w_push;
  logic                w_pop;
  logic                w_merge;
  logic                w_alloc;
  logic [PTR_W-1:0]    w_young;

  assign w_enq_ready = (count_q != c_full);
  // Address 0 completes the handshake but is dropped on the floor.
  assign w_push      = bus.enq_valid && w_enq_ready && (bus.enq_addr != 5'd0);
  assign w_pop       = bus.drain_en && (count_q != '0);
  assign w_young     = tail_q - c_ptr_one;

`ifdef WBQ_COALESCE_EN
  // Merge into the youngest entry unless that entry is leaving this edge.
  assign w_merge = w_push && (count_q != '0) &&
                   (mem_addr_q[w_young] == bus.enq_addr) &&
                   !(w_pop && (count_q == c_cnt_one));
`else
  assign w_merge = 1'b0;
`endif

  assign w_alloc = w_push && !w_merge;

  always_comb begin
    head_d  = w_pop   ? head_q + c_ptr_one : head_q;
    tail_d  = w_alloc ? tail_q + c_ptr_one : tail_q;
    count_d = count_q + (w_alloc ? c_cnt_one : '0) - (w_pop ? c_cnt_one : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      regwrite_q <= w_pop;
      if (w_pop) begin
        waddr_q <= mem_addr_q[head_q];
        wdata_q <= mem_data_q[head_q];
      end
      if (w_alloc) begin
        mem_addr_q[tail_q] <= bus.enq_addr;
        mem_data_q[tail_q] <= bus.enq_data;
      end
      if (w_merge) begin
        mem_data_q[w_young] <= bus.enq_data;
      end
    end
  end

  // Youngest-match search: start with the output stage (lowest priority),
  // then walk the queue oldest to newest so later matches override earlier.
  function automatic logic [bit_size:0] lookup(input logic [4:0] ra);
    logic                hit;
    logic [bit_size-1:0] data;
    logic [PTR_W-1:0]    idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (ra != 5'd0) begin
      if (regwrite_q && (waddr_q == ra)) begin
        hit  = 1'b1;
        data = wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if (((PTR_W+1)'(i) < count_q) && (mem_addr_q[idx] == ra)) begin
          hit  = 1'b1;
          data = mem_data_q[idx];
        end
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    {bus.fwd_hit_1, bus.fwd_data_1} = lookup(bus.Read_addr_1);
    {bus.fwd_hit_2, bus.fwd_data_2} = lookup(bus.Read_addr_2);
  end

  assign bus.enq_ready  = w_enq_ready;
  assign bus.RegWrite   = regwrite_q;
  assign bus.Write_addr = waddr_q;
  assign bus.Write_data = wdata_q;
  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0) && !regwrite_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Directed self-checking bench for wb_write_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;

  localparam int BW = 32;
  localparam int PW = 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  wb_write_queue_if #(.bit_size(BW), .PTR_W(PW)) bus ();

  wb_write_queue #(.bit_size(BW), .DEPTH(4), .PTR_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [BW-1:0] d);
    bus.enq_valid = v;
    bus.enq_addr  = a;
    bus.enq_data  = d;
  endtask

  initial begin
    int        k;
    int        maxc;
    bit        seen;
    bit        done;
    logic [BW-1:0] exp_first;

    rst             = 1'b1;
    bus.enq_valid   = 1'b0;
    bus.enq_addr    = '0;
    bus.enq_data    = '0;
    bus.drain_en    = 1'b0;
    bus.Read_addr_1 = '0;
    bus.Read_addr_2 = '0;

    // ---------------- reset state
    @(negedge clk);
    check("rst_regwrite", bus.RegWrite, 0);
    check("rst_waddr", bus.Write_addr, 0);
    check("rst_wdata", bus.Write_data, 0);
    check("rst_count", bus.count, 0);
    check("rst_ready", bus.enq_ready, 1);
    check("rst_empty", bus.empty, 1);
    check("rst_fwd1", {bus.fwd_hit_1, bus.fwd_data_1}, 0);
    rst = 1'b0;

    // ---------------- single write latency
    bus.drain_en    = 1'b1;
    bus.Read_addr_1 = 5'd5;
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    tick();                                   // E0: accepted
    drive(1'b0, 5'd0, '0);
    check("t1_count_e0", bus.count, 1);
    check("t1_rw_e0", bus.RegWrite, 0);
    check("t1_fwd_queue", {bus.fwd_hit_1, bus.fwd_data_1}, {1'b1, 32'hDEADBEEF});
    tick();                                   // E1: popped
    check("t1_rw_e1", bus.RegWrite, 1);
    check("t1_waddr", bus.Write_addr, 5);
    check("t1_wdata", bus.Write_data, 32'hDEADBEEF);
    check("t1_fwd_out", {bus.fwd_hit_1, bus.fwd_data_1}, {1'b1, 32'hDEADBEEF});
    tick();                                   // E2: committed
    check("t1_rw_e2", bus.RegWrite, 0);
    check("t1_empty", bus.empty, 1);
    check("t1_waddr_hold", bus.Write_addr, 5);
    check("t1_fwd_gone", bus.fwd_hit_1, 0);

    // ---------------- fill to full, then ordered drain
    bus.drain_en = 1'b0;
    for (int a = 1; a <= 4; a++) begin
      drive(1'b1, a[4:0], 32'h100 + a);
      tick();
    end
    check("t2_count_full", bus.count, 4);
    check("t2_ready_full", bus.enq_ready, 0);
    drive(1'b1, 5'd9, 32'h999);
    tick();
    check("t2_count_5th", bus.count, 4);
    bus.Read_addr_1 = 5'd3;
    bus.Read_addr_2 = 5'd9;
    #1;
    check("t2_fwd_3", {bus.fwd_hit_1, bus.fwd_data_1}, {1'b1, 32'h103});
    check("t2_fwd_9", bus.fwd_hit_2, 0);
    drive(1'b0, 5'd0, '0);
    bus.drain_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("t2_drain_rw", bus.RegWrite, 1);
      check("t2_drain_addr", bus.Write_addr, j + 1);
      check("t2_drain_data", bus.Write_data, 32'h101 + j);
      if (j == 0) check("t2_ready_back", bus.enq_ready, 1);
    end
    tick();
    check("t2_rw_after", bus.RegWrite, 0);
    check("t2_empty", bus.empty, 1);

    // ---------------- same-address forwarding / coalescing
    bus.drain_en    = 1'b0;
    bus.Read_addr_1 = 5'd7;
    bus.Read_addr_2 = 5'd0;
    drive(1'b1, 5'd7, 32'h11);
    tick();
    drive(1'b1, 5'd7, 32'h22);
    tick();
    drive(1'b0, 5'd0, '0);
    check("t3_fwd1", {bus.fwd_hit_1, bus.fwd_data_1}, {1'b1, 32'h22});
    check("t3_fwd2", bus.fwd_hit_2, 0);
`ifdef WBQ_COALESCE_EN
    check("t3_count", bus.count, 1);
    exp_first = 32'h22;
`else
    check("t3_count", bus.count, 2);
    exp_first = 32'h11;
`endif
    bus.drain_en = 1'b1;
    tick();
    check("t3_first_data", bus.Write_data, exp_first);
    check("t3_fwd_prio", {bus.fwd_hit_1, bus.fwd_data_1}, {1'b1, 32'h22});
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      tick();
      if (bus.empty) done = 1'b1;
    end
    check("t3_drained", done, 1);

    // ---------------- address 0 is accepted and discarded
    drive(1'b1, 5'd0, 32'hABC);
    bus.Read_addr_1 = 5'd0;
    #1;
    check("t4_ready", bus.enq_ready, 1);
    tick();
    drive(1'b0, 5'd0, '0);
    check("t4_count", bus.count, 0);
    check("t4_rw", bus.RegWrite, 0);
    check("t4_fwd0", bus.fwd_hit_1, 0);
    tick();
    check("t4_rw_next", bus.RegWrite, 0);

    // ---------------- reset while a write is in flight
    bus.drain_en = 1'b0;
    for (int a = 10; a <= 12; a++) begin
      drive(1'b1, a[4:0], 32'h200 + a);
      tick();
    end
    drive(1'b0, 5'd0, '0);
    bus.drain_en = 1'b1;
    tick();
    check("t5_rw_before", bus.RegWrite, 1);
    check("t5_addr_before", bus.Write_addr, 10);
    #2 rst = 1'b1;
    #1;
    check("t5_rw_cancel", bus.RegWrite, 0);
    check("t5_count_rst", bus.count, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.RegWrite) seen = 1'b1;
    end
    check("t5_no_writes", seen, 0);
    check("t5_empty", bus.empty, 1);

    // ---------------- sustained stream across pointer wrap
    bus.drain_en = 1'b1;
    k    = 0;
    maxc = 0;
    for (int i = 0; i < 25; i++) begin
      if (i < 20) drive(1'b1, 5'((i % 30) + 1), 32'h1000 + i);
      else        drive(1'b0, 5'd0, '0);
      tick();
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
      if (bus.RegWrite) begin
        check("t6_addr", bus.Write_addr, (k % 30) + 1);
        check("t6_data", bus.Write_data, 32'h1000 + k);
        k++;
      end
    end
    check("t6_total", k, 20);
    check("t6_maxcount", maxc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-side master for the 32-entry register file write port (RegWrite / Write_addr / Write_data).
- Buffers writeback requests from the datapath (ALU results, cache load returns) in a small FIFO.
- Drains the FIFO one write per cycle into the register file.
- Forwards pending (not yet committed) data to the two register-file read addresses, so readers never see stale values.

Parameters:
- bit_size, 32, data width; must match the register file.
- DEPTH, 4, queue entries; power of 2, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- enq_valid  in  1  writeback request valid.
- enq_ready  out  1  queue can accept a request.
- enq_addr  in  5  destination register.
- enq_data  in  bit_size  destination value.
- drain_en  in  1  permit a pop this cycle. 0 pauses the drain, used by the test/debug stall.
- RegWrite  out  1  register file write enable.
- Write_addr  out  5  register file write address.
- Write_data  out  bit_size  register file write data.
- Read_addr_1  in  5  first read address snooped for forwarding.
- Read_addr_2  in  5  second read address snooped for forwarding.
- fwd_hit_1  out  1  a pending write matches Read_addr_1.
- fwd_data_1  out  bit_size  youngest pending data for Read_addr_1.
- fwd_hit_2  out  1  a pending write matches Read_addr_2.
- fwd_data_2  out  bit_size  youngest pending data for Read_addr_2.
- count  out  PTR_W+1  queue entries held (excludes the output stage).
- empty  out  1  count==0 and RegWrite==0.

Behaviour:
- Reset (async, immediate):
  - All entries invalid; head/tail pointers 0; count 0.
  - RegWrite, Write_addr, Write_data all 0.
  - enq_ready 1; empty 1; fwd_hit_* 0; fwd_data_* 0.
- Enqueue:
  - Accepted at the posedge when enq_valid && enq_ready. enq_ready = (count != DEPTH); it does not depend on a same-cycle pop.
  - enq_addr==0: accepted (handshake completes) but discarded. Never stored, never forwarded.
- Pop / output stage:
  - At the posedge when drain_en && count!=0: head entry moves into the output register. RegWrite=1, Write_addr/Write_data = entry, for exactly one cycle. The register file commits it at the following edge.
  - No pop that cycle: RegWrite=0; Write_addr/Write_data hold their last value.
- Latency: request accepted at edge E0 gives RegWrite high during E1..E2, committed at E2. Back-to-back pops give RegWrite high on consecutive cycles.
- Simultaneous enqueue + pop: both occur and count is unchanged. A request accepted into an empty queue is never popped in the same edge.
- Ordering: strict FIFO. Multiple writes to the same address commit in enqueue order.
- Pointer wrap: head/tail wrap modulo DEPTH. count disambiguates full from empty.
- Forwarding (combinational from state and Read_addr_*):
  - Searched set: the valid queue entries plus the output stage when RegWrite=1.
  - Hit when the address matches and Read_addr != 0.
  - Data from the youngest match. Priority: newest queue entry first, then older entries, then the output stage last.
  - The current-cycle enq_* is NOT forwarded.
  - No match: fwd_hit=0, fwd_data=0.
- Full boundary: with count==DEPTH, enq_ready=0 and enq_valid is ignored. enq_ready returns to 1 the cycle after a pop.
- drain_en=0 with a full queue: stays full indefinitely; forwarding remains correct.
- Reset mid-operation: pending entries are lost and not written. A RegWrite pulse in flight is cancelled immediately.

Optional Feature:
- Macro: WBQ_COALESCE_EN.
- Defined:
  - An accepted request whose enq_addr equals the address of the youngest valid queue entry overwrites that entry's data; tail and count are unchanged.
  - Exception: if that entry is the head being popped at the same edge, a new entry is allocated normally.
  - enq_ready is still (count != DEPTH).
- Undefined: every accepted nonzero-address request allocates a new entry.

Test Plan:
- Reset, drain_en=1, then enqueue (addr 5, 0xDEADBEEF) -> RegWrite=1, Write_addr=5, Write_data=0xDEADBEEF in the second cycle after acceptance, for one cycle only; empty=1 afterwards.
- drain_en=0, enqueue 4 requests to addrs 1,2,3,4 -> count=4, enq_ready=0, a 5th request is not accepted. Set drain_en=1 -> four RegWrite pulses in order 1,2,3,4 on consecutive cycles.
- drain_en=0, enqueue (7,0x11) then (7,0x22); Read_addr_1=7, Read_addr_2=0:
  - fwd_hit_1=1, fwd_data_1=0x22 (0x11 is stale); fwd_hit_2=0.
  - Without WBQ_COALESCE_EN, count=2. With it, count=1.
- Enqueue to addr 0 -> enq_ready handshake completes, count stays 0, no RegWrite, forwarding on addr 0 never hits.
- Hold 3 entries pending, assert rst mid-drain while RegWrite=1 -> RegWrite=0 immediately, count=0, no further writes after rst deasserts.
- Sustained enqueue and drain every cycle for 20 requests (pointer wrap) -> all 20 committed in order; count never exceeds 1.
